gemm_seq_param: RTL and testbench

- Parametrised, handshaked successor to the fixed 2x2 GEMM pipeline. Computes C = A x B, or C = C_prev + A x B when accumulate mode is selected.
- A is MxK, B is KxN, elements are unsigned WIDTH-bit. The block is output-stationary with an MxN array of multiply-accumulate cells, and applies one rank-1 update (one k index) per cycle.
- It sits between a matrix-tile producer and consumer, with valid/ready on both sides.

---
 rtl/gemm_pkg.sv | 20 ++
 rtl/gemm_mac_cell.sv | 28 ++
 rtl/gemm_seq_param.sv | 106 ++++++++++
 tb/tb_gemm_seq_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared types and helpers for the sequential GEMM block
package gemm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bit offset of element [row][col] in a row-major flattened matrix
  function automatic int flat_off(input int row, input int col, input int ncols, input int width);
    return (row * ncols + col) * width;
  endfunction

  // Width of the k counter; a 1-bit counter is kept even when K==1
  function automatic int kcnt_w(input int k);
    return $clog2(k > 1 ? k : 2);
  endfunction

endpackage

// File: rtl/gemm_mac_cell.sv
// rtl/gemm_mac_cell.sv - one output-stationary multiply-accumulate cell
module gemm_mac_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_base,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] prod;

  // Lower WIDTH bits of the product only; wrap is intended
  assign prod = a * b;

  // Accumulate one rank-1 term per enabled cycle; clr_base restarts from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr_base ? '0 : acc) + prod;
    end
  end

endmodule

// File: rtl/gemm_seq_param.sv
// rtl/gemm_seq_param.sv - handshaked MxN output-stationary GEMM, one k per cycle
module gemm_seq_param
  import gemm_pkg::*;
#(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int K     = 2,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 acc_en,
  input  logic [M*K*WIDTH-1:0] A,
  input  logic [K*N*WIDTH-1:0] B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M*N*WIDTH-1:0] out
);

  localparam int            KW     = kcnt_w(K);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  state_t                 state;
  logic [KW-1:0]          k_cnt;
  logic [M*K*WIDTH-1:0]   a_q;
  logic [K*N*WIDTH-1:0]   b_q;
  logic                   acc_q;
  logic [WIDTH-1:0]       a_col [M];
  logic [WIDTH-1:0]       b_row [N];
  logic                   mac_en;
  logic                   clr_base;

  // Only the first k step of an overwrite operation discards the held C
  assign mac_en   = (state == COMPUTE);
  assign clr_base = (k_cnt == '0) && !acc_q;

  // Column k of the captured A and row k of the captured B feed the array
  for (genvar i = 0; i < M; i++) begin : g_acol
    assign a_col[i] = WIDTH'(a_q >> flat_off(i, int'(k_cnt), K, WIDTH));
  end
  for (genvar j = 0; j < N; j++) begin : g_brow
    assign b_row[j] = WIDTH'(b_q >> flat_off(int'(k_cnt), j, N, WIDTH));
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      gemm_mac_cell #(.WIDTH(WIDTH)) u_cell (
        .clk      (clk),
        .rst      (rst),
        .en       (mac_en),
        .clr_base (clr_base),
        .a        (a_col[i]),
        .b        (b_row[j]),
        .acc      (out[flat_off(i, j, N, WIDTH) +: WIDTH])
      );
    end
  end

  // Control FSM: capture operands, step k through K cycles, hold result until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k_cnt     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= A;
            b_q      <= B;
            acc_q    <= acc_en;
            k_cnt    <= '0;
            in_ready <= 1'b0;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (k_cnt == K_LAST) begin
            k_cnt     <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k_cnt <= k_cnt + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_seq_param.sv
// tb/tb_gemm_seq_param.sv - self-checking bench for gemm_seq_param
module tb_gemm_seq_param;

  logic         clk = 1'b0;
  logic         rst;

  logic         iv1, ir1, ae1, ov1, or1;
  logic [127:0] A1, B1, o1;

  logic         iv2, ir2, ae2, ov2, or2;
  logic [95:0]  A2;
  logic [31:0]  B2;
  logic [23:0]  o2;

  int n_vec  = 0;
  int n_fail = 0;

  logic [127:0] c1, c2;

  always #5 clk = ~clk;

  gemm_seq_param dut (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .acc_en(ae1),
    .A(A1), .B(B1), .out_valid(ov1), .out_ready(or1), .out(o1)
  );

  gemm_seq_param #(.M(3), .N(1), .K(4), .WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .acc_en(ae2),
    .A(A2), .B(B2), .out_valid(ov2), .out_ready(or2), .out(o2)
  );

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         acc;
    logic [127:0] exp;
    string        name;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // C = (acc ? prev : 0) + A x B, each element modulo 2^w
  function automatic logic [127:0] gemm_ref(input int m, input int n, input int k, input int w,
                                            input logic [127:0] a, input logic [127:0] b,
                                            input logic [127:0] prev, input logic acc);
    logic [127:0] res, mask, s, ea, eb;
    mask = (128'd1 << w) - 128'd1;
    res  = '0;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        s = acc ? ((prev >> ((i * n + j) * w)) & mask) : '0;
        for (int kk = 0; kk < k; kk++) begin
          ea = (a >> ((i * k + kk) * w)) & mask;
          eb = (b >> ((kk * n + j) * w)) & mask;
          s  = (s + ea * eb) & mask;
        end
        res = res | (s << ((i * n + j) * w));
      end
    end
    return res;
  endfunction

  task automatic do_op(input int sel, input logic [127:0] a, input logic [127:0] b,
                       input logic acc, input logic [127:0] exp, input string name);
    int lat;
    int klat;
    klat = (sel != 0) ? 4 : 2;
    @(negedge clk);
    if (sel == 0) begin
      iv1 = 1'b1; A1 = a; B1 = b; ae1 = acc;
    end else begin
      iv2 = 1'b1; A2 = a[95:0]; B2 = b[31:0]; ae2 = acc;
    end
    chk({name, " in_ready"}, (sel != 0) ? ir2 : ir1, 128'd1);
    @(posedge clk); #1;
    if (sel == 0) begin
      iv1 = 1'b0; A1 = {$urandom, $urandom, $urandom, $urandom}; B1 = {$urandom, $urandom, $urandom, $urandom}; ae1 = 1'($urandom);
    end else begin
      iv2 = 1'b0; A2 = {$urandom, $urandom, $urandom}; B2 = $urandom; ae2 = 1'($urandom);
    end
    lat = 0;
    while (!((sel != 0) ? ov2 : ov1) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, lat, klat);
    chk({name, " out"}, (sel != 0) ? {104'd0, o2} : o1, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] a, b, na, nb, e, ne;
    logic         acc;
    int           lat;

    rst = 1'b0;
    iv1 = 1'b0; ae1 = 1'b0; A1 = '0; B1 = '0; or1 = 1'b1;
    iv2 = 1'b0; ae2 = 1'b0; A2 = '0; B2 = '0; or2 = 1'b1;
    c1 = '0; c2 = '0;

    tbl[0] = '{a: {32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd8, 32'd7, 32'd6, 32'd5}, acc: 1'b0,
               exp: {32'd50, 32'd43, 32'd22, 32'd19}, name: "basic"};
    tbl[1] = '{a: {32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd8, 32'd7, 32'd6, 32'd5}, acc: 1'b1,
               exp: {32'd100, 32'd86, 32'd44, 32'd38}, name: "accum"};
    tbl[2] = '{a: {32'd1, 32'd0, 32'd0, 32'd1}, b: {32'd9, 32'd9, 32'd9, 32'd9}, acc: 1'b0,
               exp: {32'd9, 32'd9, 32'd9, 32'd9}, name: "ident"};
    tbl[3] = '{a: {96'd0, 32'hFFFF_FFFF}, b: {96'd0, 32'd2}, acc: 1'b0,
               exp: {96'd0, 32'hFFFF_FFFE}, name: "wrap_mul"};
    tbl[4] = '{a: {96'd0, 32'd1}, b: {96'd0, 32'd2}, acc: 1'b1,
               exp: 128'd0, name: "wrap_add"};

    #12;
    chk("reset in_ready", ir1, 128'd1);
    chk("reset out_valid", ov1, 128'd0);
    chk("reset out", o1, 128'd0);
    chk("reset2 out", o2, 128'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_op(0, tbl[i].a, tbl[i].b, tbl[i].acc, tbl[i].exp, tbl[i].name);
      c1 = gemm_ref(2, 2, 2, 32, tbl[i].a, tbl[i].b, c1, tbl[i].acc);
    end

    for (int r = 0; r < 12; r++) begin
      if (r < 4) begin
        a = {32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15))};
        b = {32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15))};
      end else begin
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
      end
      acc = 1'($urandom_range(0, 1));
      e = gemm_ref(2, 2, 2, 32, a, b, c1, acc);
      do_op(0, a, b, acc, e, "rand");
      c1 = e;
    end

    // Backpressure: result held in DONE while new operands wait
    or1 = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    e = gemm_ref(2, 2, 2, 32, a, b, c1, 1'b0);
    na = {$urandom, $urandom, $urandom, $urandom};
    nb = {$urandom, $urandom, $urandom, $urandom};
    ne = gemm_ref(2, 2, 2, 32, na, nb, e, 1'b1);
    @(negedge clk);
    iv1 = 1'b1; A1 = a; B1 = b; ae1 = 1'b0;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", lat, 2);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      iv1 = 1'b1; A1 = na; B1 = nb; ae1 = 1'b1;
      @(posedge clk); #1;
      chk("bp out", o1, e);
      chk("bp out_valid", ov1, 128'd1);
      chk("bp in_ready", ir1, 128'd0);
    end
    @(negedge clk);
    or1 = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", ov1, 128'd0);
    chk("bp release in_ready", ir1, 128'd1);
    @(posedge clk); #1;
    chk("bp accept in_ready", ir1, 128'd0);
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp next latency", lat, 2);
    chk("bp next out", o1, ne);
    c1 = ne;
    @(posedge clk); #1;

    // Reset asserted during the second COMPUTE cycle
    @(negedge clk);
    iv1 = 1'b1; A1 = {$urandom, $urandom, $urandom, $urandom}; B1 = {$urandom, $urandom, $urandom, $urandom}; ae1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst out_valid", ov1, 128'd0);
    chk("midrst in_ready", ir1, 128'd1);
    chk("midrst out", o1, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    c1 = '0;
    c2 = '0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    e = gemm_ref(2, 2, 2, 32, a, b, c1, 1'b1);
    do_op(0, a, b, 1'b1, e, "post_rst");
    c1 = e;

    // Non-square 3x1, K=4, 8-bit
    a = {32'd0, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1};
    b = {96'd0, 8'd40, 8'd30, 8'd20, 8'd10};
    do_op(1, a, b, 1'b0, 128'h2C2C2C, "nsq");
    c2 = gemm_ref(3, 1, 4, 8, a, b, c2, 1'b0);
    for (int r = 0; r < 6; r++) begin
      a = {32'd0, $urandom, $urandom, $urandom};
      b = {96'd0, $urandom};
      acc = 1'($urandom_range(0, 1));
      e = gemm_ref(3, 1, 4, 8, a, b, c2, acc);
      do_op(1, a, b, acc, e, "nsq_rand");
      c2 = e;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
